// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM: wait for a request, drive the memory for one cycle, then acknowledge.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Port 0 is the instruction fetch side, port 1 the data access side.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // Default geometry: 8K x 8 unified memory, up to four locked beats per owner.
  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LOCK_MAX = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester wins,
// and on a tie the port that was not granted last time wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // Pick the winner from the current requests and the last owner.
  always_comb begin
    gnt_o   = PORT_FETCH;
    valid_o = |req_i;
    case (req_i)
      2'b01:   gnt_o = PORT_FETCH;
      2'b10:   gnt_o = PORT_DATA;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = PORT_FETCH;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between instruction fetch (port 0)
// and data access (port 1). One access takes ACCESS + RESP, so a busy port
// gets one beat every two cycles. An owner holding lock keeps the memory
// for up to LOCK_MAX back-to-back beats before the other port gets a turn.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_inData,
  output logic              mem_writeEn,
  input  logic [DATA_W-1:0] mem_outData,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_e             state_q,   state_d;
  logic               owner_q,   owner_d;
  logic [CNT_W-1:0]   beatCnt_q, beatCnt_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [DATA_W-1:0]  wdata_q,   wdata_d;
  logic               we_q,      we_d;
  logic               lock_q,    lock_d;
  logic [DATA_W-1:0]  rdata0_q,  rdata0_d;
  logic [DATA_W-1:0]  rdata1_q,  rdata1_d;

  logic arbGnt;
  logic arbValid;
  logic ownerReq;
  logic doLatch;
  logic latchPort;

  rr_arbiter2 u_arb (
    .req_i   ({req1, req0}),
    .last_i  (owner_q),
    .gnt_o   (arbGnt),
    .valid_o (arbValid)
  );

  assign ownerReq = (owner_q == PORT_DATA) ? req1 : req0;

  // Next-state logic: grant, drive the memory for one cycle, acknowledge,
  // then either continue a locked burst, re-arbitrate, or fall back to idle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    beatCnt_d = beatCnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    lock_d    = lock_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    doLatch   = 1'b0;
    latchPort = PORT_FETCH;

    case (state_q)
      ST_IDLE: begin
        if (arbValid) begin
          doLatch   = 1'b1;
          latchPort = arbGnt;
          owner_d   = arbGnt;
          beatCnt_d = CNT_W'(1);
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          if (owner_q == PORT_DATA) rdata1_d = mem_outData;
          else                      rdata0_d = mem_outData;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (lock_q && ownerReq && (beatCnt_q < CNT_W'(LOCK_MAX))) begin
          doLatch   = 1'b1;
          latchPort = owner_q;
          beatCnt_d = beatCnt_q + CNT_W'(1);
          state_d   = ST_ACCESS;
        end else if (arbValid) begin
          doLatch   = 1'b1;
          latchPort = arbGnt;
          owner_d   = arbGnt;
          beatCnt_d = CNT_W'(1);
          state_d   = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (doLatch) begin
      if (latchPort == PORT_DATA) begin
        addr_d  = addr1;
        wdata_d = wdata1;
        we_d    = we1;
        lock_d  = lock1;
      end else begin
        addr_d  = addr0;
        wdata_d = wdata0;
        we_d    = we0;
        lock_d  = lock0;
      end
    end
  end

  // State register; reset drops anything in flight and makes port 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_DATA;
      beatCnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      lock_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      beatCnt_q <= beatCnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      lock_q    <= lock_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // The latched fields drive the memory pins directly so the address holds
  // between accesses; write enable is only ever raised in ACCESS and never under reset.
  assign mem_address = addr_q;
  assign mem_inData  = wdata_q;
  assign mem_writeEn = (state_q == ST_ACCESS) && we_q && !rst;
  assign ack0        = (state_q == ST_RESP) && (owner_q == PORT_FETCH) && !rst;
  assign ack1        = (state_q == ST_RESP) && (owner_q == PORT_DATA) && !rst;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized two-port
// phase, all checked by a scoreboard of expected read data per port.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqS   [2];
  logic        weS    [2];
  logic        lockS  [2];
  logic [12:0] addrS  [2];
  logic [7:0]  wdataS [2];
  logic        ack0, ack1;
  logic [7:0]  rdata0, rdata1;
  logic [12:0] mem_address;
  logic [7:0]  mem_inData, mem_outData;
  logic        mem_writeEn, busy, owner;

  logic [7:0]  memArr [8192];
  logic [7:0]  shadow [8192];
  logic [7:0]  expQ0 [$];
  logic [7:0]  expQ1 [$];
  logic [7:0]  lastExp [2];
  logic [7:0]  heldRd [2];
  int          ackPortLog [$];
  int          ackCycLog  [$];
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  logic        monEn  = 1'b0;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (reqS[0]),
    .req1        (reqS[1]),
    .we0         (weS[0]),
    .we1         (weS[1]),
    .lock0       (lockS[0]),
    .lock1       (lockS[1]),
    .addr0       (addrS[0]),
    .addr1       (addrS[1]),
    .wdata0      (wdataS[0]),
    .wdata1      (wdataS[1]),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .mem_address (mem_address),
    .mem_inData  (mem_inData),
    .mem_writeEn (mem_writeEn),
    .mem_outData (mem_outData),
    .busy        (busy),
    .owner       (owner)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Initial memory image: a fixed "program", with byte 0 = E0 and byte 1000 = 01.
  function automatic logic [7:0] progByte(input int i);
    if (i == 0)    return 8'hE0;
    if (i == 1000) return 8'h01;
    return 8'(i * 29 + 7) ^ 8'(i >> 5);
  endfunction

  // Behavioural 8Kx8 memory: combinational read, write on the rising edge.
  assign mem_outData = memArr[mem_address];
  initial begin
    for (int i = 0; i < 8192; i++) memArr[i] = progByte(i);
    forever begin
      @(posedge clk);
      if (mem_writeEn) memArr[mem_address] <= mem_inData;
    end
  end

  // Single comparison point: every check goes through here and bumps the counters.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: on every falling edge pop the scoreboard for any acked port,
  // otherwise require read data to be held; also log ack order and timing.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cycle++;
      if (monEn && !rst) begin
        checkOutput("ackExclusive", 32'(ack0 & ack1), 32'd0);
        checkOutput("writeEnOnlyWhenBusy", 32'(mem_writeEn & ~busy), 32'd0);
        if (ack0) begin
          ackPortLog.push_back(0);
          ackCycLog.push_back(cycle);
          checkOutput("ownerAtAck0", 32'(owner), 32'd0);
          if (expQ0.size() == 0) begin
            checkOutput("unexpectedAck0", 32'(ack0), 32'd0);
          end else begin
            e = expQ0.pop_front();
            checkOutput("rdata0", 32'(rdata0), 32'(e));
            heldRd[0] = e;
          end
        end else begin
          checkOutput("rdata0Hold", 32'(rdata0), 32'(heldRd[0]));
        end
        if (ack1) begin
          ackPortLog.push_back(1);
          ackCycLog.push_back(cycle);
          checkOutput("ownerAtAck1", 32'(owner), 32'd1);
          if (expQ1.size() == 0) begin
            checkOutput("unexpectedAck1", 32'(ack1), 32'd0);
          end else begin
            e = expQ1.pop_front();
            checkOutput("rdata1", 32'(rdata1), 32'(e));
            heldRd[1] = e;
          end
        end else begin
          checkOutput("rdata1Hold", 32'(rdata1), 32'(heldRd[1]));
        end
      end
    end
  end

  // Hold reset for two edges and clear the scoreboard and model state that reset discards.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      reqS[p] = 1'b0; weS[p] = 1'b0; lockS[p] = 1'b0; addrS[p] = '0; wdataS[p] = '0;
    end
    repeat (2) @(negedge clk);
    expQ0.delete();
    expQ1.delete();
    lastExp[0] = 8'h00; lastExp[1] = 8'h00;
    heldRd[0]  = 8'h00; heldRd[1]  = 8'h00;
    ackPortLog.delete();
    ackCycLog.delete();
    rst = 1'b0;
  endtask

  // Issue one transaction on port p and push the read data the requester should see at its ack.
  task automatic applyStimulus(input int p, input logic we, input logic lk,
                               input logic [12:0] a, input logic [7:0] d);
    logic [7:0] e;
    if (we) begin
      shadow[a] = d;
      e = lastExp[p];
    end else begin
      e = shadow[a];
      lastExp[p] = e;
    end
    if (p == 0) expQ0.push_back(e);
    else        expQ1.push_back(e);
    reqS[p] = 1'b1; weS[p] = we; lockS[p] = lk; addrS[p] = a; wdataS[p] = d;
  endtask

  // Wait (bounded) for the ack of port p; returns the number of falling edges waited.
  task automatic waitAck(input int p, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if ((p == 0) ? ack0 : ack1) break;
      if (lat >= 40) begin
        checkOutput($sformatf("ackTimeout%0d", p), 32'(lat), 32'd0);
        break;
      end
    end
  endtask

  // Random traffic for one port inside its own address window, with random gaps and locks.
  task automatic randDriver(input int p, input int n);
    int lat;
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        reqS[p] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      applyStimulus(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    13'(p * 4096 + $urandom_range(0, 63)), 8'($urandom));
      waitAck(p, lat);
    end
    reqS[p] = 1'b0;
  endtask

  // Main sequence of directed scenarios followed by the randomized phase.
  initial begin
    int lat;
    int expOrder3 [4];
    int expOrder4 [7];
    expOrder3 = '{0, 1, 0, 1};
    expOrder4 = '{1, 1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 8192; i++) shadow[i] = progByte(i);
    for (int p = 0; p < 2; p++) begin
      reqS[p] = 1'b0; weS[p] = 1'b0; lockS[p] = 1'b0; addrS[p] = '0; wdataS[p] = '0;
    end

    // Reset values.
    doReset();
    monEn = 1'b1;
    checkOutput("rstAck0", 32'(ack0), 32'd0);
    checkOutput("rstAck1", 32'(ack1), 32'd0);
    checkOutput("rstRdata0", 32'(rdata0), 32'd0);
    checkOutput("rstRdata1", 32'(rdata1), 32'd0);
    checkOutput("rstWriteEn", 32'(mem_writeEn), 32'd0);
    checkOutput("rstAddress", 32'(mem_address), 32'd0);
    checkOutput("rstInData", 32'(mem_inData), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOwner", 32'(owner), 32'd1);

    // Single fetch read of address 1000: ack two cycles later with 01.
    applyStimulus(0, 1'b0, 1'b0, 13'd1000, 8'h00);
    waitAck(0, lat);
    checkOutput("readLatency", 32'(lat), 32'd2);
    checkOutput("read1000", 32'(rdata0), 32'h01);
    reqS[0] = 1'b0;

    // Data port writes A5 to 2000, then fetch port reads it back.
    applyStimulus(1, 1'b1, 1'b0, 13'd2000, 8'hA5);
    waitAck(1, lat);
    reqS[1] = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 13'd2000, 8'h00);
    waitAck(0, lat);
    checkOutput("rawRdata", 32'(rdata0), 32'hA5);
    reqS[0] = 1'b0;
    @(negedge clk);
    checkOutput("mem2000", 32'(memArr[2000]), 32'hA5);

    // Both ports request continuously from reset: strict alternation starting with port 0.
    doReset();
    fork
      begin
        int l0;
        applyStimulus(0, 1'b0, 1'b0, 13'd100, 8'h00);
        waitAck(0, l0);
        applyStimulus(0, 1'b0, 1'b0, 13'd101, 8'h00);
        waitAck(0, l0);
        reqS[0] = 1'b0;
      end
      begin
        int l1;
        applyStimulus(1, 1'b0, 1'b0, 13'd4200, 8'h00);
        waitAck(1, l1);
        applyStimulus(1, 1'b0, 1'b0, 13'd4201, 8'h00);
        waitAck(1, l1);
        reqS[1] = 1'b0;
      end
    join
    @(negedge clk);
    checkOutput("rrAckCount", 32'(ackPortLog.size()), 32'd4);
    for (int i = 0; i < 4 && i < ackPortLog.size(); i++)
      checkOutput($sformatf("rrOrder%0d", i), 32'(ackPortLog[i]), 32'(expOrder3[i]));
    for (int i = 1; i < 4 && i < ackCycLog.size(); i++)
      checkOutput($sformatf("rrGap%0d", i), 32'(ackCycLog[i] - ackCycLog[i-1]), 32'd2);

    // Locked burst of six beats on port 1 against a waiting port 0.
    doReset();
    fork
      begin
        int l1;
        applyStimulus(1, 1'b0, 1'b1, 13'd4300, 8'h00);
        for (int k = 1; k < 6; k++) begin
          waitAck(1, l1);
          applyStimulus(1, 1'b0, 1'b1, 13'(4300 + k), 8'h00);
        end
        waitAck(1, l1);
        reqS[1] = 1'b0;
      end
      begin
        int l0;
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 13'd200, 8'h00);
        waitAck(0, l0);
        reqS[0] = 1'b0;
      end
    join
    @(negedge clk);
    checkOutput("lockAckCount", 32'(ackPortLog.size()), 32'd7);
    for (int i = 0; i < 7 && i < ackPortLog.size(); i++)
      checkOutput($sformatf("lockOrder%0d", i), 32'(ackPortLog[i]), 32'(expOrder4[i]));

    // Reset lands during the ACCESS cycle of a write: the write must be dropped.
    doReset();
    applyStimulus(1, 1'b1, 1'b0, 13'd50, 8'h3C);
    @(negedge clk);
    checkOutput("writeEnInAccess", 32'(mem_writeEn), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("writeEnUnderRst", 32'(mem_writeEn), 32'd0);
    reqS[1] = 1'b0;
    repeat (2) @(negedge clk);
    expQ1.delete();
    shadow[50] = progByte(50);
    lastExp[0] = 8'h00; lastExp[1] = 8'h00;
    heldRd[0]  = 8'h00; heldRd[1]  = 8'h00;
    rst = 1'b0;
    checkOutput("mem50Unchanged", 32'(memArr[50]), 32'(progByte(50)));
    checkOutput("idleAfterRst", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("stillIdle", 32'(busy), 32'd0);

    // Fetch stream over addresses 0..35, one ack every two cycles.
    for (int a = 0; a < 36; a++) begin
      applyStimulus(0, 1'b0, 1'b0, 13'(a), 8'h00);
      waitAck(0, lat);
      checkOutput($sformatf("streamLat%0d", a), 32'(lat), 32'd2);
      if (a == 0) checkOutput("streamAddr0", 32'(rdata0), 32'hE0);
    end
    reqS[0] = 1'b0;

    // Randomized concurrent traffic on both ports.
    fork
      randDriver(0, 60);
      randDriver(1, 60);
    join
    repeat (3) @(negedge clk);
    checkOutput("drained0", 32'(expQ0.size()), 32'd0);
    checkOutput("drained1", 32'(expQ1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends even if something wedges.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
